// File: rtl/ras_stack_pkg.sv
// Shared types for the return-address stack: predecoder update, prediction
// and the decoded per-cycle stack operation.
package ras_stack_pkg;

  localparam int unsigned RasDepth = 4;
  localparam int unsigned AddrW    = 32;

  typedef struct packed {
    logic             push;
    logic             pop;
    logic [AddrW-1:0] ra;
  } ras_update_t;

  typedef struct packed {
    logic             valid;
    logic [AddrW-1:0] ra;
  } ras_predict_t;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } ras_op_e;

endpackage

// File: rtl/ras_stack_if.sv
// Predecoder/BJU-facing bundle of the return-address stack; the stack side
// uses the slave modport.
interface ras_stack_if #(
  parameter int unsigned Depth = ras_stack_pkg::RasDepth
);
  logic                      flush_i;
  ras_stack_pkg::ras_update_t  update_i;
  ras_stack_pkg::ras_predict_t predict_o;
  logic [$clog2(Depth):0]    count_o;
  logic                      overflow_o;
  logic                      underflow_o;

  modport master (
    output flush_i, update_i,
    input  predict_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, update_i,
    output predict_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/ras_stack.sv
// Return-address stack: circular flop array with a saturating occupancy count.
// The prediction is read combinationally from the registered top entry.
module ras_stack
  import ras_stack_pkg::*;
#(
  parameter int unsigned Depth = RasDepth,
  localparam int unsigned IdxW = $clog2(Depth)
) (
  input logic        clock,
  input logic        reset,
  ras_stack_if.slave bus
);

  localparam logic [IdxW:0]   CntFull = (IdxW+1)'(Depth);
  localparam logic [IdxW:0]   CntOne  = (IdxW+1)'(1);
  localparam logic [IdxW-1:0] TopOne  = IdxW'(1);

  logic [AddrW-1:0] mem_r [Depth];
  logic [IdxW-1:0]  top_r;
  logic [IdxW:0]    cnt_r;
  logic             overflow_r;
  logic             underflow_r;

  logic [IdxW-1:0]  top_nxt_s;
  logic [IdxW:0]    cnt_nxt_s;
  logic             wr_en_s;
  logic [IdxW-1:0]  wr_idx_s;
  logic             overflow_nxt_s;
  logic             underflow_nxt_s;
  ras_op_e          op_s;

  // Decode the push/pop strobes into a single stack operation.
  always_comb begin
    op_s = OP_HOLD;
    case ({bus.update_i.push, bus.update_i.pop})
      2'b10:   op_s = OP_PUSH;
      2'b01:   op_s = OP_POP;
      2'b11:   op_s = OP_SWAP;
      default: op_s = OP_HOLD;
    endcase
  end

  // Next pointer/count, entry write and event pulses; flush beats any update.
  always_comb begin
    top_nxt_s       = top_r;
    cnt_nxt_s       = cnt_r;
    wr_en_s         = 1'b0;
    wr_idx_s        = top_r;
    overflow_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;
    if (bus.flush_i) begin
      top_nxt_s = '0;
      cnt_nxt_s = '0;
    end else begin
      case (op_s)
        OP_SWAP: begin
          // Coroutine switch replaces the top in place; an empty stack gains it.
          wr_en_s = 1'b1;
          if (cnt_r == '0) begin
            cnt_nxt_s = CntOne;
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        OP_PUSH: begin
          top_nxt_s = top_r + TopOne;
          wr_idx_s  = top_r + TopOne;
          wr_en_s   = 1'b1;
          if (cnt_r == CntFull) begin
            overflow_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CntOne;
          end
        end
        OP_POP: begin
          if (cnt_r == '0) begin
            underflow_nxt_s = 1'b1;
          end else begin
            top_nxt_s = top_r - TopOne;
            cnt_nxt_s = cnt_r - CntOne;
          end
        end
        OP_HOLD: begin
          top_nxt_s = top_r;
        end
        default: begin
          top_nxt_s = top_r;
        end
      endcase
    end
  end

  // Pointer, count and event pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      top_r       <= '0;
      cnt_r       <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      top_r       <= top_nxt_s;
      cnt_r       <= cnt_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  // Entry storage is never cleared: stale contents are masked by valid.
  always_ff @(posedge clock) begin
    if (wr_en_s && !reset) begin
      mem_r[wr_idx_s] <= bus.update_i.ra;
    end
  end

  assign bus.predict_o.valid = (cnt_r != '0);
  assign bus.predict_o.ra    = mem_r[top_r];
  assign bus.count_o         = cnt_r;
  assign bus.overflow_o      = overflow_r;
  assign bus.underflow_o     = underflow_r;

endmodule

// File: tb/tb_ras_stack.sv
// Bench for ras_stack: Depth=4 and Depth=8 instances driven with identical
// stimulus, checked against directed constants and a list-based model.
module tb_ras_stack;
  import ras_stack_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ras_stack_if #(.Depth(4)) bus4 ();
  ras_stack_if #(.Depth(8)) bus8 ();

  ras_stack #(.Depth(4)) dut4 (.clock(clock), .reset(reset), .bus(bus4.slave));
  ras_stack #(.Depth(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8.slave));

  int checks = 0;
  int errors = 0;

  // Model: index 0 mirrors Depth=4, index 1 Depth=8; list element 0 is oldest.
  logic [31:0] mdl [2][8];
  int          msz [2];
  logic        exp_ovf [2];
  logic        exp_udf [2];

  function automatic void model_apply(input int sel, input int depth, input logic fl,
                                      input logic do_push, input logic do_pop,
                                      input logic [31:0] ra);
    exp_ovf[sel] = 1'b0;
    exp_udf[sel] = 1'b0;
    if (fl) begin
      msz[sel] = 0;
    end else if (do_push && do_pop) begin
      if (msz[sel] == 0) begin
        mdl[sel][0] = ra;
        msz[sel] = 1;
      end else begin
        mdl[sel][msz[sel]-1] = ra;
      end
    end else if (do_push) begin
      if (msz[sel] == depth) begin
        for (int i = 0; i < depth - 1; i++) mdl[sel][i] = mdl[sel][i+1];
        mdl[sel][depth-1] = ra;
        exp_ovf[sel] = 1'b1;
      end else begin
        mdl[sel][msz[sel]] = ra;
        msz[sel] = msz[sel] + 1;
      end
    end else if (do_pop) begin
      if (msz[sel] == 0) exp_udf[sel] = 1'b1;
      else msz[sel] = msz[sel] - 1;
    end
  endfunction

  task automatic step(input logic fl, input logic do_push, input logic do_pop,
                      input logic [31:0] ra);
    bus4.flush_i  = fl;
    bus8.flush_i  = fl;
    bus4.update_i = '{push: do_push, pop: do_pop, ra: ra};
    bus8.update_i = '{push: do_push, pop: do_pop, ra: ra};
    model_apply(0, 4, fl, do_push, do_pop, ra);
    model_apply(1, 8, fl, do_push, do_pop, ra);
    @(posedge clock);
    #1;
    bus4.flush_i  = 1'b0;
    bus8.flush_i  = 1'b0;
    bus4.update_i = '0;
    bus8.update_i = '0;
  endtask

  task automatic do_reset(input logic do_push, input logic [31:0] ra);
    reset = 1'b1;
    bus4.update_i = '{push: do_push, pop: 1'b0, ra: ra};
    bus8.update_i = '{push: do_push, pop: 1'b0, ra: ra};
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus4.update_i = '0;
    bus8.update_i = '0;
    for (int s = 0; s < 2; s++) begin
      msz[s] = 0;
      exp_ovf[s] = 1'b0;
      exp_udf[s] = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset(1'b1, 32'h8000_0FF0);
    checks++;
    if (bus4.predict_o.valid !== 1'b0 || bus4.count_o !== 3'd0) begin
      errors++;
      $display("FAIL reset_d4 valid %0b count %0d want 0 0", bus4.predict_o.valid, bus4.count_o);
    end
    checks++;
    if (bus8.predict_o.valid !== 1'b0 || bus8.count_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_d8 valid %0b count %0d want 0 0", bus8.predict_o.valid, bus8.count_o);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (bus4.underflow_o !== 1'b1 || bus4.count_o !== 3'd0 || bus8.underflow_o !== 1'b1) begin
      errors++;
      $display("FAIL underflow udf4 %0b udf8 %0b count %0d want 1 1 0",
               bus4.underflow_o, bus8.underflow_o, bus4.count_o);
    end
    step(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus4.underflow_o !== 1'b0) begin
      errors++;
      $display("FAIL underflow_pulse udf4 %0b want 0", bus4.underflow_o);
    end
  endtask

  task automatic test_lifo();
    logic [31:0] vals [3];
    vals[0] = 32'h8000_0010;
    vals[1] = 32'h8000_0020;
    vals[2] = 32'h8000_0030;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, vals[i]);
    checks++;
    if (bus4.count_o !== 3'd3 || bus4.predict_o.ra !== 32'h8000_0030 ||
        bus8.count_o !== 4'd3 || bus8.predict_o.ra !== 32'h8000_0030) begin
      errors++;
      $display("FAIL lifo_top count %0d/%0d ra %h/%h want 3 80000030",
               bus4.count_o, bus8.count_o, bus4.predict_o.ra, bus8.predict_o.ra);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus4.predict_o.ra !== vals[2-k] || bus8.predict_o.ra !== vals[2-k] ||
          bus4.predict_o.valid !== 1'b1) begin
        errors++;
        $display("FAIL lifo_pop%0d ra %h/%h want %h", k, bus4.predict_o.ra, bus8.predict_o.ra, vals[2-k]);
      end
      step(1'b0, 1'b0, 1'b1, 32'h0);
    end
    checks++;
    if (bus4.predict_o.valid !== 1'b0 || bus8.predict_o.valid !== 1'b0) begin
      errors++;
      $display("FAIL lifo_empty valid %0b/%0b want 0", bus4.predict_o.valid, bus8.predict_o.valid);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] base;
    base = 32'h9000_0000;
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b1, 1'b0, base + 32'(i));
      if (i == 4 || i == 5 || i == 8 || i == 9) begin
        checks++;
        if (bus4.overflow_o !== (i >= 5) || bus8.overflow_o !== (i == 9)) begin
          errors++;
          $display("FAIL ovf_push%0d ovf4 %0b ovf8 %0b want %0b %0b",
                   i, bus4.overflow_o, bus8.overflow_o, (i >= 5), (i == 9));
        end
      end
    end
    checks++;
    if (bus4.count_o !== 3'd4 || bus8.count_o !== 4'd8) begin
      errors++;
      $display("FAIL ovf_count count %0d/%0d want 4 8", bus4.count_o, bus8.count_o);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (bus8.predict_o.ra !== base + 32'(9 - k) || bus8.predict_o.valid !== 1'b1 ||
          bus4.predict_o.valid !== (k < 4) ||
          (k < 4 && bus4.predict_o.ra !== base + 32'(9 - k))) begin
        errors++;
        $display("FAIL ovf_pop%0d ra4 %h v4 %0b ra8 %h want %h", k, bus4.predict_o.ra,
                 bus4.predict_o.valid, bus8.predict_o.ra, base + 32'(9 - k));
      end
      step(1'b0, 1'b0, 1'b1, 32'h0);
      if (k >= 4) begin
        checks++;
        if (bus4.underflow_o !== 1'b1 || bus8.underflow_o !== 1'b0) begin
          errors++;
          $display("FAIL ovf_udf%0d udf4 %0b udf8 %0b want 1 0", k, bus4.underflow_o, bus8.underflow_o);
        end
      end
    end
    checks++;
    if (bus8.predict_o.valid !== 1'b0 || bus8.count_o !== 4'd0) begin
      errors++;
      $display("FAIL ovf_empty valid8 %0b count8 %0d want 0 0", bus8.predict_o.valid, bus8.count_o);
    end
  endtask

  task automatic test_push_pop();
    step(1'b0, 1'b1, 1'b0, 32'h8000_00F0);
    step(1'b0, 1'b1, 1'b0, 32'h8000_0100);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0200);
    checks++;
    if (bus4.predict_o.ra !== 32'h8000_0200 || bus4.count_o !== 3'd2 ||
        bus8.predict_o.ra !== 32'h8000_0200 || bus8.count_o !== 4'd2) begin
      errors++;
      $display("FAIL swap ra %h count %0d want 80000200 2", bus4.predict_o.ra, bus4.count_o);
    end
    step(1'b0, 1'b0, 1'b1, 32'h0);
    checks++;
    if (bus4.predict_o.ra !== 32'h8000_00F0 || bus4.count_o !== 3'd1) begin
      errors++;
      $display("FAIL swap_below ra %h count %0d want 800000f0 1", bus4.predict_o.ra, bus4.count_o);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h8000_0200);
    checks++;
    if (bus4.count_o !== 3'd1 || bus4.predict_o.ra !== 32'h8000_0200 ||
        bus4.underflow_o !== 1'b0 || bus8.count_o !== 4'd1) begin
      errors++;
      $display("FAIL swap_empty count %0d ra %h udf %0b want 1 80000200 0",
               bus4.count_o, bus4.predict_o.ra, bus4.underflow_o);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'hA000_0000 + 32'(i));
    checks++;
    if (bus4.count_o !== 3'd3) begin
      errors++;
      $display("FAIL flush_pre count %0d want 3", bus4.count_o);
    end
    step(1'b1, 1'b1, 1'b0, 32'hA000_00FF);
    checks++;
    if (bus4.count_o !== 3'd0 || bus4.predict_o.valid !== 1'b0 || bus4.overflow_o !== 1'b0 ||
        bus8.count_o !== 4'd0) begin
      errors++;
      $display("FAIL flush count %0d valid %0b ovf %0b want 0 0 0",
               bus4.count_o, bus4.predict_o.valid, bus4.overflow_o);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 32'hB000_0000 + 32'(i));
    step(1'b1, 1'b1, 1'b0, 32'hB000_00FF);
    checks++;
    if (bus4.count_o !== 3'd0 || bus4.overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_full count %0d ovf %0b want 0 0", bus4.count_o, bus4.overflow_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] ra4;
    logic [31:0] ra8;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(63) == 0) begin
        do_reset(1'($urandom_range(1)), $urandom);
      end else begin
        step(($urandom_range(15) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom);
      end
      ra4 = (msz[0] != 0) ? mdl[0][msz[0]-1] : bus4.predict_o.ra;
      ra8 = (msz[1] != 0) ? mdl[1][msz[1]-1] : bus8.predict_o.ra;
      checks++;
      if (int'(bus4.count_o) != msz[0] || bus4.predict_o.valid !== (msz[0] != 0) ||
          bus4.overflow_o !== exp_ovf[0] || bus4.underflow_o !== exp_udf[0] ||
          bus4.predict_o.ra !== ra4) begin
        errors++;
        $display("FAIL rand_d4 n %0d count %0d/%0d ovf %0b/%0b udf %0b/%0b ra %h/%h", n,
                 bus4.count_o, msz[0], bus4.overflow_o, exp_ovf[0], bus4.underflow_o,
                 exp_udf[0], bus4.predict_o.ra, ra4);
      end
      checks++;
      if (int'(bus8.count_o) != msz[1] || bus8.predict_o.valid !== (msz[1] != 0) ||
          bus8.overflow_o !== exp_ovf[1] || bus8.underflow_o !== exp_udf[1] ||
          bus8.predict_o.ra !== ra8) begin
        errors++;
        $display("FAIL rand_d8 n %0d count %0d/%0d ovf %0b/%0b udf %0b/%0b ra %h/%h", n,
                 bus8.count_o, msz[1], bus8.overflow_o, exp_ovf[1], bus8.underflow_o,
                 exp_udf[1], bus8.predict_o.ra, ra8);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus4.flush_i = 1'b0;
    bus8.flush_i = 1'b0;
    bus4.update_i = '0;
    bus8.update_i = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_lifo();
    test_overflow();
    test_push_pop();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras_stack.md
# ras_stack

Parametrised return-address stack for the OoO frontend BPU, replacing the fixed-depth RAS. It consumes `ras_update_t` from the predecoder and serves `ras_predict_t` to next-PC selection for `CF_RET` instructions. Compared with the fixed version it adds:
- configurable depth;
- circular overwrite on overflow;
- a combined push+pop (coroutine) case;
- a flush path driven by the BJU on mispredict.

## Interface

Parameters:
- `Depth`, default 4: number of entries; a power of two, at least 2.
- `IdxW`, default `$clog2(Depth)`: pointer width; derived, not overridden.

Ports:
- `clock`  in  1: the single clock.
- `reset`  in  1: synchronous, active-high reset.
- `flush_i`  in  1: discard all speculative contents (BJU mispredict).
- `update_i`  in  `ras_update_t`: `push`, `pop`, `ra`.
- `predict_o`  out  `ras_predict_t`: `valid` plus top-of-stack `ra`.
- `count_o`  out  `IdxW+1`: number of valid entries, 0..`Depth`.
- `overflow_o`  out  1: one-cycle pulse when a push overwrites the oldest entry.
- `underflow_o`  out  1: one-cycle pulse when a pop is requested while empty.

## Operation

State:
- `mem[Depth]` of 32 bits.
- `top` (`IdxW` bits), index of the current top entry.
- `cnt` (`IdxW+1` bits).

Outputs:
- `predict_o.ra = mem[top]`, combinational.
- `predict_o.valid = (cnt != 0)`.
- `count_o = cnt`.

Per-cycle actions, priority highest first:
- **reset:** `top=0`, `cnt=0`, pulses 0. `mem` is not cleared, because `valid` gates it.
- **flush_i:** `top=0`, `cnt=0`. Push and pop in the same cycle are ignored.
- **push & pop:** `mem[top] = ra`; `top` and `cnt` unchanged. If `cnt==0`, write `mem[top]` and set `cnt=1`; `underflow_o` stays 0.
- **push only:** `top = top+1` (mod `Depth`, wraps); `mem[top+1] = ra`; `cnt = min(cnt+1, Depth)`. If `cnt==Depth` before the push, the oldest entry is overwritten and `overflow_o=1` for the next cycle.
- **pop only:** if `cnt>0`: `top = top-1` (mod `Depth`), `cnt = cnt-1`. If `cnt==0`: no state change and `underflow_o=1`.
- **neither:** hold.

Arithmetic:
- `top` arithmetic is modular in `IdxW` bits. No extra wrap logic is needed because `Depth` is a power of two.
- `cnt` saturates at `Depth` and never goes below 0.
- After wrap-around, pops can return at most `Depth` valid addresses. Older calls are lost, and that is accepted.

## Timing

- Prediction read latency is 0 cycles: combinational from registered state.
- Update latency is 1 cycle: an update in cycle N is visible on `predict_o` in N+1.
- The predecoder consumes `predict_o` and issues `pop` in the same cycle. The address used is the pre-pop top.
- `overflow_o` and `underflow_o` are registered and asserted in cycle N+1 for an event in cycle N.
- Reset in the middle of a push/pop sequence: the next cycle has `cnt=0` and `valid=0` regardless of the update.
- No handshake: `update_i` fields are qualified only by `push` and `pop`, which are single-cycle strobes.

## Structure

- `ras_update_t` and `ras_predict_t` remain in `OoO_pkg`.
- Add `localparam int unsigned RasDepth = 4` to `OoO_pkg`; the instantiation in the BPU passes `Depth(OoO_pkg::RasDepth)`.
- Single module, no sub-modules. `mem` is a flop array: `Depth` is small and the combinational read requires flops.
- Follow-up, not in scope: checkpoint `top`/`cnt` per branch for precise recovery. `flush_i` is the only recovery mechanism in this generation.

## Test plan

- **Reset then idle:** after reset, `predict_o.valid=0` and `count_o=0`. Pop with no push → `underflow_o=1` one cycle later; `count_o` stays 0.
- **Depth=4, LIFO:**
  - Push 0x8000_0010, 0x8000_0020, 0x8000_0030.
  - Expect `count_o=3` and `ra=0x8000_0030`.
  - Then three pops → `ra` reads 0x30, 0x20, 0x10 in order, then `valid=0`.
- **Overflow wrap, Depth=4:**
  - Push A, B, C, D, E.
  - The fifth push pulses `overflow_o`; `count_o=4`.
  - Four pops yield E, D, C, B; then `valid=0`.
- **Push+pop together:**
  - With top = 0x8000_0100, assert push+pop with `ra`=0x8000_0200.
  - Next cycle: `ra=0x8000_0200`, `count_o` unchanged.
  - On an empty stack the same stimulus gives `count_o=1`.
- **Flush priority:** with `count_o=3`, assert `flush_i` together with a push → next cycle `count_o=0`, `valid=0`, no `overflow_o` pulse.
- **Parametrisation:** repeat the LIFO and overflow scenarios with `Depth=8`. The ninth push overwrites the first entry; eight pops return entries 9 down to 2.
